instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, 255, max cycles in FETCH without imem_ack before error (range 1..255).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 next_pc  input  16  next PC from the next-PC mux (pc+1 or zero-extended jump target).
REQ-006 pc  output  16  current PC register, fed back to the next-PC mux.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  16  read address, equals pc.
REQ-009 imem_ack  input  1  memory read complete; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  input  16  instruction word from memory.
REQ-011 instr  output  16  captured instruction to decode.
REQ-012 instr_valid  output  1  instr holds a valid, unconsumed word.
REQ-013 instr_ready  input  1  decode accepts instr this cycle.
REQ-014 fetch_err  output  1  sticky fetch timeout flag.
REQ-015 fetch_count  output  16  count of instructions handed to decode.

Function
REQ-016 FSM SHALL have states FETCH, HOLD, ERROR; encoding from shared constants.
REQ-017 FETCH: imem_req=1, imem_addr=pc, instr_valid=0; on imem_ack=1 at a clock edge, instr<=imem_rdata and state<=HOLD.
REQ-018 imem_req SHALL be a registered-state decode (high only in FETCH), deasserted the cycle after ack.
REQ-019 HOLD: imem_req=0, instr_valid=1, instr stable; on instr_ready=1, pc<=next_pc, fetch_count<=fetch_count+1, state<=FETCH.
REQ-020 instr_ready while not in HOLD SHALL be ignored; no PC or count change.
REQ-021 imem_ack outside FETCH SHALL be ignored.
REQ-022 Minimum throughput: one instruction per 2 cycles (ack in first FETCH cycle, ready in first HOLD cycle).
REQ-023 pc SHALL change only on the HOLD->FETCH transition; next_pc sampled at that edge only (jump/no-jump resolved upstream).
REQ-024 pc wraps naturally: next_pc=16'hFFFF+1 handling is upstream; pc accepts any 16-bit value incl. 16'h0000 after 16'hFFFF.
REQ-025 fetch_count SHALL wrap 16'hFFFF->16'h0000 silently.
REQ-026 Wait counter: cleared on entry to FETCH, increments each FETCH cycle without ack; reaching TIMEOUT with no ack -> state<=ERROR, fetch_err<=1.
REQ-027 Ack in the same cycle the counter reaches TIMEOUT SHALL win: capture instr, go HOLD, no error.
REQ-028 ERROR: imem_req=0, instr_valid=0, pc frozen; exit only via reset.

Reset
REQ-029 On rst_n=0, immediately and independent of clk: state=FETCH, pc=RESET_PC, instr=16'h0000, fetch_err=0, fetch_count=0, wait counter=0.
REQ-030 Outputs during reset: imem_req=1 only after rst_n deasserts and first rising edge occurs; while rst_n=0, imem_req=0, instr_valid=0.
REQ-031 Reset mid-fetch or mid-HOLD SHALL discard the in-flight/held word; a late imem_ack after reset release applies to the fresh RESET_PC request only if in FETCH.

Structure
REQ-032 Shared constants file cpu_defs SHALL hold PC width (16), instruction width (16), FSM state encodings, default TIMEOUT.
REQ-033 Wait counter SHALL be a sub-module fetch_timeout_ctr (clear, enable, terminal-count output); all else inline.

Verification
REQ-034 Reset release, imem_ack on first FETCH cycle with rdata=16'h1234, instr_ready=1 -> imem_addr=16'h0000, instr=16'h1234 valid one cycle, pc then = next_pc (drive 16'h0001), fetch_count=1.
REQ-035 Backpressure: instr_ready=0 for 5 HOLD cycles -> instr_valid and instr stable, imem_req=0, pc unchanged; ready=1 -> pc<=next_pc.
REQ-036 Jump: in HOLD drive next_pc=16'h0ABC, ready=1 -> next cycle imem_addr=16'h0ABC.
REQ-037 Timeout: TIMEOUT=4, no ack -> after 4 FETCH cycles fetch_err=1, imem_req=0; ack then ignored; rst_n pulse clears fetch_err, pc=RESET_PC.
REQ-038 Ack on terminal cycle (TIMEOUT=4, ack in 4th cycle) -> HOLD, fetch_err=0.
REQ-039 Async reset asserted mid-HOLD between clock edges -> instr_valid=0 and pc=RESET_PC before next edge; fetch_count=0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU constants: datapath widths, fetch FSM encodings and timeout defaults.
package cpu_defs_pkg;

    localparam int unsigned PC_W            = 16;
    localparam int unsigned INSTR_W         = 16;
    localparam int unsigned WAIT_CNT_W      = 8;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ERROR = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Wait-cycle counter for an outstanding instruction fetch.
// terminal_c flags the cycle in which a further miss would reach TIMEOUT.
module fetch_timeout_ctr
    import cpu_defs_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal_c
);

    logic [WAIT_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + WAIT_CNT_W'(1);
        end
    end

    assign terminal_c = (cnt == WAIT_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests imem at pc, holds the word for decode,
// advances pc on hand-off and latches a sticky error on memory timeout.
module instr_fetch
    import cpu_defs_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter int unsigned     TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_W-1:0]    next_pc,
    output logic [PC_W-1:0]    pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               fetch_err,
    output logic [15:0]        fetch_count
);

    fetch_state_e state, state_d;
    logic         fetch_active;
    logic         take;
    logic         accept;
    logic         timed_out;
    logic         wait_en;
    logic         wait_tc;

    // A request is only live once imem_req has been raised after reset.
    assign fetch_active = (state == ST_FETCH) && imem_req;
    assign take         = fetch_active && imem_ack;
    assign accept       = (state == ST_HOLD) && instr_ready;
    assign wait_en      = fetch_active && !imem_ack;
    assign timed_out    = wait_en && wait_tc;
    assign imem_addr    = pc;

    fetch_timeout_ctr #(
        .TIMEOUT   (TIMEOUT)
    ) u_wait_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (!wait_en),
        .enable    (wait_en),
        .terminal_c(wait_tc)
    );

    always_comb begin
        state_d = state;
        case (state)
            ST_FETCH: begin
                if (take) begin
                    state_d = ST_HOLD;
                end else if (timed_out) begin
                    state_d = ST_ERROR;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    state_d = ST_FETCH;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            pc          <= RESET_PC;
            fetch_err   <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_d;
            imem_req    <= (state_d == ST_FETCH);
            instr_valid <= (state_d == ST_HOLD);
            if (take) begin
                instr <= imem_rdata;
            end
            if (accept) begin
                pc          <= next_pc;
                fetch_count <= fetch_count + 16'(1);
            end
            if (timed_out) begin
                fetch_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with TIMEOUT=4.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [15:0] next_pc;
    logic [15:0] pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;
    logic [15:0] fetch_count;

    int n_chk;
    int n_err;

    instr_fetch #(
        .RESET_PC   (16'h0000),
        .TIMEOUT    (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .next_pc    (next_pc),
        .pc         (pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .fetch_err  (fetch_err),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        next_pc     = '0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;

        // Reset values before any clock edge
        #3;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_err", 32'(fetch_err), 32'h0);
        chk("rst_cnt", 32'(fetch_count), 32'h0);
        chk("rst_instr", 32'(instr), 32'h0);
        tick();
        tick();
        chk("rst_req_clk", 32'(imem_req), 32'h0);

        // Release; request rises only after the first edge
        rst_n = 1'b1;
        chk("rel_req_pre", 32'(imem_req), 32'h0);
        tick();
        chk("rel_req", 32'(imem_req), 32'h1);
        chk("rel_addr", 32'(imem_addr), 32'h0000);

        // Back-to-back fetch: ack and ready in first cycles
        imem_ack = 1'b1; imem_rdata = 16'h1234; instr_ready = 1'b1; next_pc = 16'h0001;
        tick();
        imem_ack = 1'b0;
        chk("f1_valid", 32'(instr_valid), 32'h1);
        chk("f1_instr", 32'(instr), 32'h1234);
        chk("f1_req", 32'(imem_req), 32'h0);
        chk("f1_pc_hold", 32'(pc), 32'h0000);
        tick();
        instr_ready = 1'b0;
        chk("f1_pc", 32'(pc), 32'h0001);
        chk("f1_cnt", 32'(fetch_count), 32'h1);
        chk("f1_valid_off", 32'(instr_valid), 32'h0);
        chk("f1_req_back", 32'(imem_req), 32'h1);
        chk("f1_addr", 32'(imem_addr), 32'h0001);

        // Backpressure, with stray acks in HOLD that must be ignored
        imem_ack = 1'b1; imem_rdata = 16'hBEEF; next_pc = 16'h0002;
        tick();
        imem_rdata = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(instr_valid), 32'h1);
            chk("bp_instr", 32'(instr), 32'hBEEF);
            chk("bp_req", 32'(imem_req), 32'h0);
            chk("bp_pc", 32'(pc), 32'h0001);
        end
        imem_ack = 1'b0; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("bp_pc_adv", 32'(pc), 32'h0002);
        chk("bp_cnt", 32'(fetch_count), 32'h2);

        // Ready while fetching is ignored
        instr_ready = 1'b1; next_pc = 16'h0055;
        tick();
        instr_ready = 1'b0;
        chk("rdy_ign_pc", 32'(pc), 32'h0002);
        chk("rdy_ign_cnt", 32'(fetch_count), 32'h2);
        chk("rdy_ign_req", 32'(imem_req), 32'h1);

        // Jump target taken on hand-off
        imem_ack = 1'b1; imem_rdata = 16'h4000;
        tick();
        imem_ack = 1'b0; next_pc = 16'h0ABC; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("jmp_addr", 32'(imem_addr), 32'h0ABC);
        chk("jmp_cnt", 32'(fetch_count), 32'h3);

        // Ack on the terminal wait cycle wins over the timeout
        tick(); tick(); tick();
        chk("term_err_pre", 32'(fetch_err), 32'h0);
        chk("term_req_pre", 32'(imem_req), 32'h1);
        imem_ack = 1'b1; imem_rdata = 16'h7777;
        tick();
        imem_ack = 1'b0;
        chk("term_valid", 32'(instr_valid), 32'h1);
        chk("term_instr", 32'(instr), 32'h7777);
        chk("term_err", 32'(fetch_err), 32'h0);

        // pc wrap FFFF -> 0000
        next_pc = 16'hFFFF; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("wrap_addr_ff", 32'(imem_addr), 32'hFFFF);
        imem_ack = 1'b1; imem_rdata = 16'h0101;
        tick();
        imem_ack = 1'b0; next_pc = 16'h0000; instr_ready = 1'b1;
        tick();
        chk("wrap_pc0", 32'(pc), 32'h0000);
        chk("wrap_cnt", 32'(fetch_count), 32'h5);
        instr_ready = 1'b0;
        imem_ack = 1'b1; imem_rdata = 16'h0202;
        tick();
        imem_ack = 1'b0; next_pc = 16'h0010; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("pre_tmo_pc", 32'(pc), 32'h0010);

        // Timeout after 4 unacknowledged cycles
        tick(); tick(); tick();
        chk("tmo_err_pre", 32'(fetch_err), 32'h0);
        tick();
        chk("tmo_err", 32'(fetch_err), 32'h1);
        chk("tmo_req", 32'(imem_req), 32'h0);
        chk("tmo_valid", 32'(instr_valid), 32'h0);
        imem_ack = 1'b1; imem_rdata = 16'h3333; instr_ready = 1'b1; next_pc = 16'h0099;
        tick(); tick();
        imem_ack = 1'b0; instr_ready = 1'b0;
        chk("err_ack_ign", 32'(instr_valid), 32'h0);
        chk("err_pc", 32'(pc), 32'h0010);
        chk("err_cnt", 32'(fetch_count), 32'h6);
        chk("err_sticky", 32'(fetch_err), 32'h1);

        // Reset pulse clears the error
        #2 rst_n = 1'b0;
        #1;
        chk("clr_err", 32'(fetch_err), 32'h0);
        chk("clr_pc", 32'(pc), 32'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        chk("clr_req", 32'(imem_req), 32'h1);

        // Async reset between edges while holding a word
        imem_ack = 1'b1; imem_rdata = 16'h5555; instr_ready = 1'b1; next_pc = 16'h0020;
        tick();
        imem_ack = 1'b0;
        tick();
        instr_ready = 1'b0;
        chk("ar_pc_pre", 32'(pc), 32'h0020);
        imem_ack = 1'b1; imem_rdata = 16'h6666;
        tick();
        imem_ack = 1'b0;
        chk("ar_valid_pre", 32'(instr_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(instr_valid), 32'h0);
        chk("ar_pc", 32'(pc), 32'h0000);
        chk("ar_cnt", 32'(fetch_count), 32'h0);
        chk("ar_instr", 32'(instr), 32'h0);
        chk("ar_req", 32'(imem_req), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
